front_instr_queue: RTL and testbench

FRONT_INSTR_QUEUE -- requirements
Module: front_instr_queue

---
 rtl/front_instr_queue_pkg.sv | 24 ++
 rtl/front_instr_queue_if.sv | 25 ++
 rtl/front_queue_ram.sv | 29 ++
 rtl/front_instr_queue.sv | 84 ++++++++
 tb/tb_front_instr_queue.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/front_instr_queue_pkg.sv
// Shared front-end parameters and types used by the prefetch stage and the instruction byte queue.
package front_instr_queue_pkg;

   localparam int unsigned QUEUE_BYTES = 16;
   localparam int unsigned PTR_W       = 4;
   localparam int unsigned CNT_W       = 5;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned RD_W        = 2;

   // Prefetched instruction word; lo is the lower-address byte.
   typedef struct packed {
      logic [BYTE_W-1:0] hi;
      logic [BYTE_W-1:0] lo;
   } instr_word_t;

   // Bytes actually consumed: a request of 3 means 2, never more than held.
   function automatic logic [CNT_W-1:0] consume_amount(input logic [RD_W-1:0] rd_bytes,
                                                       input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] req;
      req = (rd_bytes == RD_W'(3)) ? CNT_W'(2) : CNT_W'(rd_bytes);
      return (req > cnt) ? cnt : req;
   endfunction

endpackage

// File: rtl/front_instr_queue_if.sv
// Prefetcher/decoder side signals of the instruction byte queue.
interface front_instr_queue_if;
   import front_instr_queue_pkg::*;

   logic              flush;
   logic              skip_lo;
   instr_word_t       fifo_dat_i;
   logic              wr_fifo;
   logic              fifo_full;
   logic [BYTE_W-1:0] q_byte0;
   logic [BYTE_W-1:0] q_byte1;
   logic [CNT_W-1:0]  q_cnt;
   logic [RD_W-1:0]   rd_bytes;

   modport master (
      output flush, skip_lo, fifo_dat_i, wr_fifo, rd_bytes,
      input  fifo_full, q_byte0, q_byte1, q_cnt
   );

   modport slave (
      input  flush, skip_lo, fifo_dat_i, wr_fifo, rd_bytes,
      output fifo_full, q_byte0, q_byte1, q_cnt
   );

endinterface

// File: rtl/front_queue_ram.sv
// 16x8 byte storage: two byte write ports, two asynchronous read ports, no reset.
module front_queue_ram
   import front_instr_queue_pkg::*;
(
   input  logic              clk_i,
   input  logic              we0_i,
   input  logic [PTR_W-1:0]  waddr0_i,
   input  logic [BYTE_W-1:0] wdat0_i,
   input  logic              we1_i,
   input  logic [PTR_W-1:0]  waddr1_i,
   input  logic [BYTE_W-1:0] wdat1_i,
   input  logic [PTR_W-1:0]  raddr0_i,
   input  logic [PTR_W-1:0]  raddr1_i,
   output logic [BYTE_W-1:0] rdat0_o,
   output logic [BYTE_W-1:0] rdat1_o
);

   logic [BYTE_W-1:0] mem_q [QUEUE_BYTES];

   // Write addresses are always consecutive, so the two ports never collide.
   always_ff @(posedge clk_i) begin
      if (we0_i) mem_q[waddr0_i] <= wdat0_i;
      if (we1_i) mem_q[waddr1_i] <= wdat1_i;
   end

   assign rdat0_o = mem_q[raddr0_i];
   assign rdat1_o = mem_q[raddr1_i];

endmodule

// File: rtl/front_instr_queue.sv
// Instruction byte queue between prefetcher and decoder: 16-bit words in, 0..2 bytes out per cycle.
module front_instr_queue
   import front_instr_queue_pkg::*;
(
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   front_instr_queue_if.slave bus
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              skip_q, skip_d;

   logic              full;
   logic              wr_accept;
   logic [CNT_W-1:0]  consumed;
   logic [CNT_W-1:0]  written;
   logic              we0, we1;
   logic [BYTE_W-1:0] wdat0;

   // Full is judged on the pre-read count so a same-cycle read never frees room for a write.
   assign full      = cnt_q > CNT_W'(QUEUE_BYTES - 2);
   assign consumed  = consume_amount(bus.rd_bytes, cnt_q);
   assign wr_accept = bus.wr_fifo && !full && !bus.flush && !wb_rst_i;

   // With a pending skip only the high byte of the word enters the queue.
   assign written = !wr_accept ? '0 : (skip_q ? CNT_W'(1) : CNT_W'(2));
   assign we0     = wr_accept;
   assign we1     = wr_accept && !skip_q;
   assign wdat0   = skip_q ? bus.fifo_dat_i.hi : bus.fifo_dat_i.lo;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      skip_d   = skip_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
         skip_d   = bus.skip_lo;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(consumed);
         wr_ptr_d = wr_ptr_q + PTR_W'(written);
         cnt_d    = cnt_q + written - consumed;
         if (wr_accept) skip_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         skip_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         skip_q   <= skip_d;
      end
   end

   front_queue_ram u_ram (
      .clk_i    (wb_clk_i),
      .we0_i    (we0),
      .waddr0_i (wr_ptr_q),
      .wdat0_i  (wdat0),
      .we1_i    (we1),
      .waddr1_i (wr_ptr_q + PTR_ONE),
      .wdat1_i  (bus.fifo_dat_i.hi),
      .raddr0_i (rd_ptr_q),
      .raddr1_i (rd_ptr_q + PTR_ONE),
      .rdat0_o  (bus.q_byte0),
      .rdat1_o  (bus.q_byte1)
   );

   assign bus.fifo_full = full;
   assign bus.q_cnt     = cnt_q;

endmodule

// File: tb/tb_front_instr_queue.sv
// Bench for front_instr_queue: directed scenarios plus random traffic against a byte-queue model.
module tb_front_instr_queue;
   import front_instr_queue_pkg::*;

   logic clk = 1'b0;
   logic rst;

   front_instr_queue_if bus ();

   front_instr_queue dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: plain byte queue plus the skip-next-low-byte flag.
   logic [7:0] mq[$];
   bit         m_skip;

   task automatic tick();
      int          n;
      bit          acc;
      logic [15:0] d;
      @(posedge clk);
      d = bus.fifo_dat_i;
      if (rst) begin
         mq.delete();
         m_skip = 1'b0;
      end else if (bus.flush) begin
         mq.delete();
         m_skip = bus.skip_lo;
      end else begin
         acc = bus.wr_fifo && (mq.size() <= 14);
         n = (bus.rd_bytes == 2'd3) ? 2 : int'(bus.rd_bytes);
         if (n > mq.size()) n = mq.size();
         repeat (n) void'(mq.pop_front());
         if (acc) begin
            if (m_skip) begin
               mq.push_back(d[15:8]);
               m_skip = 1'b0;
            end else begin
               mq.push_back(d[7:0]);
               mq.push_back(d[15:8]);
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush      = 1'b0;
      bus.skip_lo    = 1'b0;
      bus.wr_fifo    = 1'b0;
      bus.rd_bytes   = 2'd0;
      bus.fifo_dat_i = 16'h0000;
   endtask

   task automatic do_flush(input bit skip);
      bus.flush   = 1'b1;
      bus.skip_lo = skip;
      tick();
      bus.flush   = 1'b0;
      bus.skip_lo = 1'b0;
   endtask

   task automatic write_word(input logic [15:0] w);
      bus.wr_fifo    = 1'b1;
      bus.fifo_dat_i = w;
      tick();
      bus.wr_fifo    = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_total++;
      if (bus.q_cnt !== 5'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.q_cnt);
      else n_pass++;
      n_total++;
      if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.fifo_full);
      else n_pass++;
   endtask

   task automatic test_basic_write();
      write_word(16'hB8A0);
      n_total++;
      if (bus.q_cnt !== 5'd2) $display("FAIL basic_cnt: got %0d expected 2", bus.q_cnt);
      else n_pass++;
      n_total++;
      if (bus.q_byte0 !== 8'hA0 || bus.q_byte1 !== 8'hB8)
         $display("FAIL basic_bytes: got %h %h expected a0 b8", bus.q_byte0, bus.q_byte1);
      else n_pass++;
   endtask

   task automatic test_skip_lo();
      do_flush(1'b1);
      write_word(16'h1234);
      n_total++;
      if (bus.q_cnt !== 5'd1 || bus.q_byte0 !== 8'h12)
         $display("FAIL skip_first: got cnt %0d byte0 %h expected cnt 1 byte0 12", bus.q_cnt, bus.q_byte0);
      else n_pass++;
      write_word(16'h5678);
      n_total++;
      if (bus.q_cnt !== 5'd3 || bus.q_byte0 !== 8'h12 || bus.q_byte1 !== 8'h78)
         $display("FAIL skip_second: got cnt %0d bytes %h %h expected 3 12 78",
                  bus.q_cnt, bus.q_byte0, bus.q_byte1);
      else n_pass++;
      bus.rd_bytes = 2'd1;
      tick();
      bus.rd_bytes = 2'd0;
      n_total++;
      if (bus.q_cnt !== 5'd2 || bus.q_byte0 !== 8'h78 || bus.q_byte1 !== 8'h56)
         $display("FAIL skip_third: got cnt %0d bytes %h %h expected 2 78 56",
                  bus.q_cnt, bus.q_byte0, bus.q_byte1);
      else n_pass++;
   endtask

   task automatic test_full();
      do_flush(1'b0);
      for (int i = 0; i < 7; i++) write_word(16'(16'h1100 + i * 16'h0202));
      n_total++;
      if (bus.q_cnt !== 5'd14 || bus.fifo_full !== 1'b0)
         $display("FAIL full_at14: got cnt %0d full %b expected 14 0", bus.q_cnt, bus.fifo_full);
      else n_pass++;
      write_word(16'hEEDD);
      n_total++;
      if (bus.q_cnt !== 5'd16 || bus.fifo_full !== 1'b1)
         $display("FAIL full_at16: got cnt %0d full %b expected 16 1", bus.q_cnt, bus.fifo_full);
      else n_pass++;
      write_word(16'hDEAD);
      n_total++;
      if (bus.q_cnt !== 5'd16 || bus.q_byte0 !== 8'h00 || bus.q_byte1 !== 8'h11)
         $display("FAIL full_ignore: got cnt %0d bytes %h %h expected 16 00 11",
                  bus.q_cnt, bus.q_byte0, bus.q_byte1);
      else n_pass++;
   endtask

   task automatic test_simul_rd_wr();
      bus.rd_bytes = 2'd1;
      tick();
      n_total++;
      if (bus.q_cnt !== 5'd15 || bus.fifo_full !== 1'b1)
         $display("FAIL simul_15: got cnt %0d full %b expected 15 1", bus.q_cnt, bus.fifo_full);
      else n_pass++;
      bus.rd_bytes   = 2'd2;
      bus.wr_fifo    = 1'b1;
      bus.fifo_dat_i = 16'hBEEF;
      tick();
      bus.wr_fifo    = 1'b0;
      n_total++;
      if (bus.q_cnt !== 5'd13 || bus.q_byte0 !== mq[0])
         $display("FAIL simul_rd_wr: got cnt %0d byte0 %h expected 13 %h", bus.q_cnt, bus.q_byte0, mq[0]);
      else n_pass++;
      bus.rd_bytes = 2'd3;
      tick();
      bus.rd_bytes = 2'd0;
      n_total++;
      if (bus.q_cnt !== 5'd11 || bus.q_byte0 !== mq[0] || bus.q_byte1 !== mq[1])
         $display("FAIL rd3_as2: got cnt %0d bytes %h %h expected 11 %h %h",
                  bus.q_cnt, bus.q_byte0, bus.q_byte1, mq[0], mq[1]);
      else n_pass++;
   endtask

   task automatic test_wrap_stream();
      logic [7:0]  exp_in[$];
      logic [7:0]  obs[$];
      logic [15:0] w;
      int          k;
      int          guard;
      bit          bad;
      do_flush(1'b0);
      bus.rd_bytes = 2'd2;
      for (int i = 0; i < 20; i++) begin
         w = 16'($urandom);
         exp_in.push_back(w[7:0]);
         exp_in.push_back(w[15:8]);
         k = (mq.size() < 2) ? mq.size() : 2;
         if (k >= 1) obs.push_back(bus.q_byte0);
         if (k == 2) obs.push_back(bus.q_byte1);
         bus.wr_fifo    = 1'b1;
         bus.fifo_dat_i = w;
         tick();
      end
      bus.wr_fifo = 1'b0;
      guard = 0;
      while (mq.size() > 0 && guard < 20) begin
         k = (mq.size() < 2) ? mq.size() : 2;
         if (k >= 1) obs.push_back(bus.q_byte0);
         if (k == 2) obs.push_back(bus.q_byte1);
         tick();
         guard++;
      end
      bus.rd_bytes = 2'd0;
      n_total++;
      if (bus.q_cnt !== 5'd0) $display("FAIL wrap_drained: got cnt %0d expected 0", bus.q_cnt);
      else n_pass++;
      bad = (obs.size() != exp_in.size());
      for (int i = 0; i < obs.size() && i < exp_in.size(); i++)
         if (obs[i] !== exp_in[i]) bad = 1'b1;
      n_total++;
      if (bad) $display("FAIL wrap_order: got %0d bytes expected %0d in order", obs.size(), exp_in.size());
      else n_pass++;
      do_flush(1'b1);
      write_word(16'hA55A);
      bus.rd_bytes = 2'd2;
      tick();
      bus.rd_bytes = 2'd0;
      n_total++;
      if (bus.q_cnt !== 5'd0) $display("FAIL cnt1_rd2: got cnt %0d expected 0", bus.q_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_flush_mid();
      do_flush(1'b0);
      bus.rd_bytes = 2'd1;
      for (int i = 0; i < 3; i++) write_word(16'($urandom));
      bus.rd_bytes   = 2'd0;
      rst            = 1'b1;
      bus.flush      = 1'b1;
      bus.wr_fifo    = 1'b1;
      bus.fifo_dat_i = 16'h7777;
      tick();
      rst = 1'b0;
      idle_inputs();
      n_total++;
      if (bus.q_cnt !== 5'd0 || bus.fifo_full !== 1'b0)
         $display("FAIL mid_reset: got cnt %0d full %b expected 0 0", bus.q_cnt, bus.fifo_full);
      else n_pass++;
      do_flush(1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      write_word(16'hCAFE);
      n_total++;
      if (bus.q_cnt !== 5'd2 || bus.q_byte0 !== 8'hFE)
         $display("FAIL reset_clears_skip: got cnt %0d byte0 %h expected 2 fe", bus.q_cnt, bus.q_byte0);
      else n_pass++;
      for (int i = 0; i < 8; i++) write_word(16'($urandom));
      bus.flush      = 1'b1;
      bus.wr_fifo    = 1'b1;
      bus.rd_bytes   = 2'd2;
      bus.fifo_dat_i = 16'h1111;
      tick();
      idle_inputs();
      n_total++;
      if (bus.q_cnt !== 5'd0 || bus.fifo_full !== 1'b0)
         $display("FAIL mid_flush: got cnt %0d full %b expected 0 0", bus.q_cnt, bus.fifo_full);
      else n_pass++;
   endtask

   task automatic test_random_traffic();
      int errs;
      errs = 0;
      do_flush(1'b0);
      for (int i = 0; i < 600; i++) begin
         bus.wr_fifo    = ($urandom_range(0, 3) != 0);
         bus.rd_bytes   = 2'($urandom_range(0, 3));
         bus.fifo_dat_i = 16'($urandom);
         bus.flush      = ($urandom_range(0, 39) == 0);
         bus.skip_lo    = 1'($urandom);
         tick();
         n_total++;
         if (bus.q_cnt !== 5'(mq.size()) || bus.fifo_full !== (mq.size() > 14)) begin
            if (errs < 10)
               $display("FAIL rand_cnt cycle %0d: got cnt %0d full %b expected %0d %b",
                        i, bus.q_cnt, bus.fifo_full, mq.size(), mq.size() > 14);
            errs++;
         end else n_pass++;
         if (mq.size() >= 2) begin
            n_total++;
            if (bus.q_byte0 !== mq[0] || bus.q_byte1 !== mq[1]) begin
               if (errs < 10)
                  $display("FAIL rand_bytes cycle %0d: got %h %h expected %h %h",
                           i, bus.q_byte0, bus.q_byte1, mq[0], mq[1]);
               errs++;
            end else n_pass++;
         end else if (mq.size() == 1) begin
            n_total++;
            if (bus.q_byte0 !== mq[0]) begin
               if (errs < 10)
                  $display("FAIL rand_byte0 cycle %0d: got %h expected %h", i, bus.q_byte0, mq[0]);
               errs++;
            end else n_pass++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic_write();
      test_skip_lo();
      test_full();
      test_simul_rd_wr();
      test_wrap_stream();
      test_reset_flush_mid();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
